// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory port.
// Latency: none; types, constants and a pure helper function only.
// Backpressure: none.
package lsu_pkg;

    localparam int BytesPerWord = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_t;

    // Fixed encodings so existing debug scripts can keep decoding the raw state bits.
    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_ACC0_ENC = 3'd1;
    localparam logic [2:0] ST_ACC1_ENC = 3'd2;
    localparam logic [2:0] ST_DATA_ENC = 3'd3;
    localparam logic [2:0] ST_RESP_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ACC0 = ST_ACC0_ENC,
        ST_ACC1 = ST_ACC1_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_RESP = ST_RESP_ENC
    } state_t;

    // Access width in bytes; the illegal code maps to a full word, but it
    // never reaches the RAM so the value only has to be harmless.
    function automatic logic [2:0] size_bytes(input size_t sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bundle of the LSU request/response handshake and the data-RAM port.
// Latency: none; wires only.
// Backpressure: req_valid/req_ready on requests; responses and RAM accesses have none.
// master: CPU execute stage plus RAM (drives requests and ram_r_data).
// slave : lsu_mem_port (drives req_ready, rsp_*, and the RAM strobes/addresses/data).
interface lsu_mem_port_if #(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [AddrBusWidth-1:0]   req_addr;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [DataBusWidth-1:0]   req_wdata;

    logic                      rsp_valid;
    logic [DataBusWidth-1:0]   rsp_rdata;
    logic                      rsp_err;

    logic                      ram_re;
    logic [AddrBusWidth-1:0]   ram_r_addr;
    logic                      ram_we;
    logic [AddrBusWidth-1:0]   ram_w_addr;
    logic [DataBusWidth-1:0]   ram_w_data;
    logic [DataBusWidth/8-1:0] ram_w_sel;
    logic [DataBusWidth-1:0]   ram_r_data;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, ram_r_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_re, ram_r_addr, ram_we, ram_w_addr, ram_w_data, ram_w_sel
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, ram_r_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_re, ram_r_addr, ram_we, ram_w_addr, ram_w_data, ram_w_sel
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/data placement and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: off/nbytes/wdata -> mask (8 lanes over two words), sdata (64-bit placed store data);
//        lo/hi/is_unsigned -> rdata (extracted, sign- or zero-extended load result).
module lsu_lane_align (
    input  logic [1:0]  off,
    input  logic [2:0]  nbytes,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic        is_unsigned,
    output logic [7:0]  mask,
    output logic [63:0] sdata,
    output logic [31:0] rdata
);
    logic [7:0]  base_mask;
    logic [4:0]  bit_shift;
    logic [63:0] rd_pair;
    logic [31:0] rd_shift;
    logic        sext;

    assign bit_shift = {off, 3'b000};
    assign base_mask = 8'((9'd1 << nbytes) - 9'd1);
    assign mask      = base_mask << off;
    assign sdata     = {32'h0, wdata} << bit_shift;

    // The low word is the first access; a split load puts its tail in hi.
    assign rd_pair  = {hi, lo};
    assign rd_shift = 32'(rd_pair >> bit_shift);
    assign sext     = !is_unsigned;

    // Full-word loads have nothing to extend, so is_unsigned does not matter there.
    always_comb begin
        rdata = rd_shift;
        case (nbytes)
            3'd1:    rdata = {{24{sext & rd_shift[7]}}, rd_shift[7:0]};
            3'd2:    rdata = {{16{sext & rd_shift[15]}}, rd_shift[15:0]};
            default: rdata = rd_shift;
        endcase
    end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store front end: one byte/half/word access per request, split over two RAM words when it straddles.
// Latency: store 2 (3 split), load 3 (4 split), illegal size 1 cycle from accept to rsp_valid.
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle pulse that cannot be stalled.
// Ports: clk, rst_n (async active-low); bus (slave side of lsu_mem_port_if) carries the
//        CPU request/response handshake and the RAM read/write ports.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_port_if.slave bus
);
    if (DataBusWidth != 32) begin : g_bad_width
        $error("lsu_mem_port: DataBusWidth must be 32");
    end

    state_t                  state;
    logic                    r_we;
    logic [AddrBusWidth-1:0] r_addr;
    logic [1:0]              r_off;
    logic [2:0]              r_n;
    logic                    r_split;
    logic                    r_uns;
    logic                    r_err;
    logic [31:0]             r_wdata;
    logic [31:0]             r_lo;
    logic [31:0]             r_hi;

    size_t                   req_sz;
    logic [2:0]              req_n;
    logic                    req_split;
    logic                    ready;
    logic                    xfer;

    logic [7:0]              lane_mask;
    logic [63:0]             lane_sdata;
    logic [31:0]             lane_rdata;

    logic                    acc0;
    logic                    acc1;
    logic                    acc;
    logic                    in_resp;
    logic [AddrBusWidth-1:0] word_addr;

    assign req_sz    = size_t'(bus.req_size);
    assign req_n     = size_bytes(req_sz);
    assign req_split = ({1'b0, bus.req_addr[1:0]} + req_n) > 3'd4;

    // Gate with rst_n so nothing is accepted while reset is held.
    assign ready = rst_n && (state == ST_IDLE);
    assign xfer  = bus.req_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_off   <= 2'd0;
            r_n     <= 3'd0;
            r_split <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 32'h0;
            r_lo    <= 32'h0;
            r_hi    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        r_we    <= bus.req_we;
                        r_addr  <= {bus.req_addr[AddrBusWidth-1:2], 2'b00};
                        r_off   <= bus.req_addr[1:0];
                        r_n     <= req_n;
                        r_split <= req_split;
                        r_uns   <= bus.req_unsigned;
                        r_err   <= (req_sz == SZ_ILL);
                        r_wdata <= bus.req_wdata;
                        // hi must read as zero for loads that never fetch a second word.
                        r_lo    <= 32'h0;
                        r_hi    <= 32'h0;
                        state   <= (req_sz == SZ_ILL) ? ST_RESP : ST_ACC0;
                    end
                end
                ST_ACC0: begin
                    if (r_we && !r_split) begin
                        state <= ST_RESP;
                    end else if (r_split) begin
                        state <= ST_ACC1;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_ACC1: begin
                    // First read word arrives while the second read is being issued.
                    if (!r_we) begin
                        r_lo <= bus.ram_r_data;
                    end
                    state <= r_we ? ST_RESP : ST_DATA;
                end
                ST_DATA: begin
                    if (r_split) begin
                        r_hi <= bus.ram_r_data;
                    end else begin
                        r_lo <= bus.ram_r_data;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    lsu_lane_align u_lane_align (
        .off         (r_off),
        .nbytes      (r_n),
        .wdata       (r_wdata),
        .lo          (r_lo),
        .hi          (r_hi),
        .is_unsigned (r_uns),
        .mask        (lane_mask),
        .sdata       (lane_sdata),
        .rdata       (lane_rdata)
    );

    assign acc0    = (state == ST_ACC0);
    assign acc1    = (state == ST_ACC1);
    assign acc     = acc0 || acc1;
    assign in_resp = (state == ST_RESP);

    // Second access targets the next word; the add wraps at the top of the address space.
    assign word_addr = acc1 ? (r_addr + AddrBusWidth'(BytesPerWord)) : r_addr;

    assign bus.req_ready  = ready;
    assign bus.ram_re     = acc && !r_we;
    assign bus.ram_we     = acc && r_we;
    assign bus.ram_r_addr = (acc && !r_we) ? word_addr : '0;
    assign bus.ram_w_addr = (acc && r_we) ? word_addr : '0;
    assign bus.ram_w_data = (acc && r_we) ? (acc1 ? lane_sdata[63:32] : lane_sdata[31:0]) : 32'h0;
    assign bus.ram_w_sel  = (acc && r_we) ? (acc1 ? lane_mask[7:4] : lane_mask[3:0]) : 4'h0;

    assign bus.rsp_valid = in_resp;
    assign bus.rsp_err   = in_resp && r_err;
    assign bus.rsp_rdata = (in_resp && !r_err && !r_we) ? lane_rdata : 32'h0;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases with literal expectations, then random traffic.
// Latency: n/a.
// Backpressure: n/a; requests are only presented while the model says the port is idle.
module tb_lsu_mem_port;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.AddrBusWidth(32), .DataBusWidth(32)) bus ();

    lsu_mem_port #(.AddrBusWidth(32), .DataBusWidth(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        ready;
        logic        re;
        logic [31:0] raddr;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wsel;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          t0     = 0;
    int          rsp_count = 0;
    int          rsp_cyc   = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;

    exp_t        expq[$];
    wr_t         wlog[$];
    logic [31:0] rlog[$];
    bit [31:0]   ram_mem [bit [31:0]];
    bit [31:0]   ref_mem [bit [31:0]];

    function automatic bit [31:0] ram_get(input bit [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
    endfunction

    function automatic bit [31:0] ref_get(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic void ref_write(input bit [31:0] a, input bit [31:0] d, input bit [3:0] sel);
        bit [31:0] w;
        w = ref_get(a);
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        ref_mem[a] = w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // RAM: byte-selectable writes, read data valid the cycle after ram_re and zero otherwise.
    always @(posedge clk) begin
        bit [31:0] w;
        if (bus.ram_we === 1'b1) begin
            w = ram_get(bus.ram_w_addr);
            for (int i = 0; i < 4; i++) begin
                if (bus.ram_w_sel[i]) w[8*i +: 8] = bus.ram_w_data[8*i +: 8];
            end
            ram_mem[bus.ram_w_addr] = w;
        end
        bus.ram_r_data <= (bus.ram_re === 1'b1) ? ram_get(bus.ram_r_addr) : 32'h0;
    end

    // Compare every cycle against the expected-cycle queue; an empty queue means idle.
    always @(negedge clk) begin
        exp_t e;
        e = '0;
        e.ready = rst_n;
        if (expq.size() > 0) e = expq.pop_front();
        chk("req_ready",  32'(bus.req_ready),  32'(e.ready));
        chk("ram_re",     32'(bus.ram_re),     32'(e.re));
        chk("ram_r_addr", bus.ram_r_addr,      e.raddr);
        chk("ram_we",     32'(bus.ram_we),     32'(e.we));
        chk("ram_w_addr", bus.ram_w_addr,      e.waddr);
        chk("ram_w_data", bus.ram_w_data,      e.wdata);
        chk("ram_w_sel",  32'(bus.ram_w_sel),  32'(e.wsel));
        chk("rsp_valid",  32'(bus.rsp_valid),  32'(e.rv));
        chk("rsp_rdata",  bus.rsp_rdata,       e.rdata);
        chk("rsp_err",    32'(bus.rsp_err),    32'(e.err));
        if (bus.ram_we === 1'b1) wlog.push_back({bus.ram_w_addr, bus.ram_w_data, bus.ram_w_sel});
        if (bus.ram_re === 1'b1) rlog.push_back(bus.ram_r_addr);
        if (bus.rsp_valid === 1'b1) begin
            rsp_count++;
            rsp_cyc    = cyc;
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
        end
    end

    // Expected per-cycle outputs after acceptance, derived from byte-level arithmetic.
    task automatic model_req(input bit we, input bit [31:0] addr, input bit [1:0] size,
                             input bit uns, input bit [31:0] wdata, output int k);
        exp_t      e;
        int        o;
        int        n;
        bit [31:0] a0;
        bit [31:0] a1;
        bit        split;
        bit [7:0]  m;
        bit [63:0] s;
        bit [63:0] v;
        longint    val;
        k = 0;
        if (size == 2'd3) begin
            e = '0; e.rv = 1'b1; e.err = 1'b1;
            expq.push_back(e);
            k = 1;
            return;
        end
        o     = int'(addr[1:0]);
        n     = 1 << size;
        a0    = addr & 32'hFFFF_FFFC;
        a1    = a0 + 32'd4;
        split = (o + n) > 4;
        m     = 8'(((1 << n) - 1) << o);
        s     = {32'h0, wdata} << (8 * o);
        if (we) begin
            e = '0; e.we = 1'b1; e.waddr = a0; e.wdata = s[31:0]; e.wsel = m[3:0];
            expq.push_back(e);
            ref_write(a0, s[31:0], m[3:0]);
            if (split) begin
                e = '0; e.we = 1'b1; e.waddr = a1; e.wdata = s[63:32]; e.wsel = m[7:4];
                expq.push_back(e);
                ref_write(a1, s[63:32], m[7:4]);
            end
            e = '0; e.rv = 1'b1;
            expq.push_back(e);
            k = split ? 3 : 2;
        end else begin
            e = '0; e.re = 1'b1; e.raddr = a0;
            expq.push_back(e);
            if (split) begin
                e = '0; e.re = 1'b1; e.raddr = a1;
                expq.push_back(e);
            end
            e = '0;
            expq.push_back(e);
            v   = {split ? ref_get(a1) : 32'h0, ref_get(a0)} >> (8 * o);
            val = longint'(v & ((64'd1 << (8 * n)) - 64'd1));
            if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
            e = '0; e.rv = 1'b1; e.rdata = val[31:0];
            expq.push_back(e);
            k = split ? 4 : 3;
        end
    endtask

    // Called at posedge+1 with the port idle; returns at posedge+1 once it is idle again.
    task automatic do_req(input bit we, input bit [31:0] addr, input bit [1:0] size,
                          input bit uns, input bit [31:0] wdata);
        exp_t e;
        int   k;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        e = '0; e.ready = 1'b1;
        expq.push_back(e);
        model_req(we, addr, size, uns, wdata, k);
        @(posedge clk); #1;
        t0 = cyc;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom());
        bus.req_addr     = $urandom();
        bus.req_size     = 2'($urandom());
        bus.req_unsigned = 1'($urandom());
        bus.req_wdata    = $urandom();
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string nm, input int idx, input bit [31:0] a,
                          input bit [31:0] d, input bit [3:0] sel);
        if (idx < wlog.size()) begin
            chk({nm, " addr"}, wlog[idx].addr, a);
            chk({nm, " data"}, wlog[idx].data, d);
            chk({nm, " sel"},  32'(wlog[idx].sel), 32'(sel));
        end else begin
            chk({nm, " count"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_lat(input string nm, input int lat);
        chk(nm, 32'(rsp_cyc - t0 + 1), 32'(lat));
    endtask

    initial begin
        exp_t      e;
        int        n0;
        int        g;
        bit [31:0] ra;
        bit [1:0]  rs;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned word store then load.
        wlog.delete();
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
        chk("sw count", 32'(wlog.size()), 32'd1);
        chk_wr("sw", 0, 32'h10, 32'hDEAD_BEEF, 4'b1111);
        chk_lat("sw latency", 2);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        chk("lw data", last_rdata, 32'hDEAD_BEEF);
        chk_lat("lw latency", 3);

        // Byte store, then signed and unsigned byte loads.
        wlog.delete();
        do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h80);
        chk_wr("sb", 0, 32'h10, 32'h8000_0000, 4'b1000);
        do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        chk("lb data", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        chk("lbu data", last_rdata, 32'h0000_0080);

        // Half store straddling two words.
        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344);
        do_req(1'b1, 32'h24, 2'd2, 1'b0, 32'h5566_7788);
        wlog.delete();
        do_req(1'b1, 32'h23, 2'd1, 1'b0, 32'h0000_ABCD);
        chk("sh split count", 32'(wlog.size()), 32'd2);
        chk_wr("sh split w0", 0, 32'h20, 32'hCD00_0000, 4'b1000);
        chk_wr("sh split w1", 1, 32'h24, 32'h0000_00AB, 4'b0001);
        chk_lat("sh split latency", 3);
        do_req(1'b0, 32'h23, 2'd1, 1'b0, 32'h0);
        chk("lh split data", last_rdata, 32'hFFFF_ABCD);
        chk_lat("lh split latency", 4);

        // Word load wrapping past the top of the address space.
        do_req(1'b1, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'hCAFE_F00D);
        do_req(1'b1, 32'h0000_0000, 2'd2, 1'b0, 32'h1234_5678);
        rlog.delete();
        do_req(1'b0, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0);
        chk("wrap read count", 32'(rlog.size()), 32'd2);
        if (rlog.size() == 2) begin
            chk("wrap read0", rlog[0], 32'hFFFF_FFFC);
            chk("wrap read1", rlog[1], 32'h0000_0000);
        end
        chk("wrap data", last_rdata, 32'h5678_CAFE);

        // Illegal size: immediate error, no RAM traffic, even for a store.
        wlog.delete();
        rlog.delete();
        do_req(1'b1, 32'h40, 2'd3, 1'b0, 32'h1234_5678);
        chk("ill err", 32'(last_err), 32'd1);
        chk("ill rdata", last_rdata, 32'h0);
        chk_lat("ill latency", 1);
        chk("ill ram traffic", 32'(wlog.size() + rlog.size()), 32'd0);

        // Reset while the second half of a split store is on the RAM port.
        wlog.delete();
        n0 = rsp_count;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_addr     = 32'h33;
        bus.req_size     = 2'd1;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0000_1234;
        e = '0; e.ready = 1'b1;
        expq.push_back(e);
        e = '0; e.we = 1'b1; e.waddr = 32'h30; e.wdata = 32'h3400_0000; e.wsel = 4'b1000;
        expq.push_back(e);
        ref_write(32'h30, 32'h3400_0000, 4'b1000);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst no rsp", 32'(rsp_count - n0), 32'd0);
        chk("rst write count", 32'(wlog.size()), 32'd1);
        do_req(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
        chk("rst lw first half", last_rdata, 32'h3400_0000);
        do_req(1'b0, 32'h34, 2'd2, 1'b0, 32'h0);
        chk("rst lw second half", last_rdata, 32'h0);

        // Random traffic over two small windows, one at the top of memory.
        for (int i = 0; i < 400; i++) begin
            g = $urandom_range(0, 2);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            ra = ($urandom_range(0, 1) == 1 ? 32'h0000_0100 : 32'hFFFF_FFC0) + 32'($urandom_range(0, 63));
            rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom()), ra, rs, 1'($urandom()), $urandom());
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
